// File: rtl/cache_defs.sv
// Shared dcache definitions: arbiter state/source encodings and set count.
package cache_defs;

  // Number of sets in the data cache; sets the default set-index width.
  localparam int DCACHE_NO_OF_SETS = 16;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } dcache_arb_state_t;

  // Source values double as bit positions in the 3-bit grant vectors.
  typedef enum logic [1:0] {
    ARB_SRC_RF  = 2'd0,
    ARB_SRC_EV  = 2'd1,
    ARB_SRC_CPU = 2'd2
  } dcache_arb_src_t;

  // One-hot grant bit for a source.
  function automatic logic [2:0] src_onehot(input dcache_arb_src_t src);
    logic [2:0] oh;
    oh = 3'b000;
    oh[src] = 1'b1;
    return oh;
  endfunction

  // Source owning a one-hot grant vector (RF when the vector is empty).
  function automatic dcache_arb_src_t onehot_src(input logic [2:0] oh);
    dcache_arb_src_t src;
    if (oh[2]) begin
      src = ARB_SRC_CPU;
    end else if (oh[1]) begin
      src = ARB_SRC_EV;
    end else begin
      src = ARB_SRC_RF;
    end
    return src;
  endfunction

endpackage

// File: rtl/dcache_arb_prio.sv
// Combinational three-way priority picker shared by the dcache RAM arbiters.
// Bit 0 = refill, bit 1 = eviction, bit 2 = CPU. Normal order is
// RF > EV > CPU; promote lifts the CPU to the top.
module dcache_arb_prio (
  input  logic [2:0] req,
  input  logic       promote,
  output logic [2:0] gnt
);

  // Pick exactly one requester (or none) in priority order.
  always_comb begin
    gnt = 3'b000;
    if (promote && req[2]) begin
      gnt = 3'b100;
    end else if (req[0]) begin
      gnt = 3'b001;
    end else if (req[1]) begin
      gnt = 3'b010;
    end else if (req[2]) begin
      gnt = 3'b100;
    end
  end

endmodule

// File: rtl/dcache_dataram_arb.sv
// Data cache data-RAM port arbiter/sequencer.
// Shares the single RAM port among refill, eviction and CPU requesters,
// supports locked multi-cycle ownership and returns per-requester rvalid
// one cycle after each grant.
// Optional macro DCACHE_ARB_AGING_EN adds a CPU age counter that promotes
// the CPU to top priority after AGE_LIMIT losing cycles.
//
// Handshake: a requester holds req/addr/wr_en/wdata stable until it sees its
// gnt high; gnt is combinational from this cycle's reqs and registered state;
// at most one gnt is high; the matching rvalid pulses in the next cycle.
module dcache_dataram_arb
  import cache_defs::*;
#(
  parameter int NUM_COL    = 16,
  parameter int COL_WIDTH  = 8,
  parameter int ADDR_WIDTH = $clog2(DCACHE_NO_OF_SETS),
  parameter int DATA_WIDTH = NUM_COL * COL_WIDTH,
  parameter int AGE_LIMIT  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rf_req,
  input  logic                  rf_lock,
  input  logic [NUM_COL-1:0]    rf_wr_en,
  input  logic [ADDR_WIDTH-1:0] rf_addr,
  input  logic [DATA_WIDTH-1:0] rf_wdata,
  output logic                  rf_gnt,
  output logic                  rf_rvalid,
  input  logic                  ev_req,
  input  logic                  ev_lock,
  input  logic [NUM_COL-1:0]    ev_wr_en,
  input  logic [ADDR_WIDTH-1:0] ev_addr,
  input  logic [DATA_WIDTH-1:0] ev_wdata,
  output logic                  ev_gnt,
  output logic                  ev_rvalid,
  input  logic                  cpu_req,
  input  logic                  cpu_lock,
  input  logic [NUM_COL-1:0]    cpu_wr_en,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_gnt,
  output logic                  cpu_rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  ram_req,
  output logic [NUM_COL-1:0]    ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  dbg_state
);

  dcache_arb_state_t state_q, state_d;
  dcache_arb_src_t   owner_q, owner_d;
  logic [2:0]        rvalid_q, rvalid_d;
  logic [2:0]        req_vec, lock_vec, idle_gnt, gnt_vec, owner_mask;
  logic              promote;

  assign req_vec  = {cpu_req, ev_req, rf_req};
  assign lock_vec = {cpu_lock, ev_lock, rf_lock};

  dcache_arb_prio u_prio (
    .req     (req_vec),
    .promote (promote),
    .gnt     (idle_gnt)
  );

`ifdef DCACHE_ARB_AGING_EN
  localparam int AGE_W = $clog2(AGE_LIMIT + 1);
  logic [AGE_W-1:0] cpu_age_q, cpu_age_d;

  // Count CPU losing cycles, saturating at AGE_LIMIT; a CPU grant clears it.
  always_comb begin
    cpu_age_d = cpu_age_q;
    if (gnt_vec[2]) begin
      cpu_age_d = '0;
    end else if (cpu_req && (cpu_age_q != AGE_W'(AGE_LIMIT))) begin
      cpu_age_d = cpu_age_q + 1'b1;
    end
  end

  // Age counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_age_q <= '0;
    end else begin
      cpu_age_q <= cpu_age_d;
    end
  end

  // Promotion only affects idle arbitration; a held lock is never broken.
  assign promote = (cpu_age_q == AGE_W'(AGE_LIMIT));
`else
  // Aging compiled out: AGE_LIMIT is never negative, so no promotion.
  assign promote = (AGE_LIMIT < 0);
`endif

  // Grant selection and lock sequencing; reset forces every grant low.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    gnt_vec    = 3'b000;
    owner_mask = src_onehot(owner_q);
    if (!rst) begin
      case (state_q)
        ARB_IDLE: begin
          gnt_vec = idle_gnt;
          if ((idle_gnt & lock_vec) != 3'b000) begin
            state_d = ARB_LOCKED;
            owner_d = onehot_src(idle_gnt);
          end
        end
        ARB_LOCKED: begin
          // Owner alone may use the port; lock=0 ends ownership whether or
          // not this cycle carried an access.
          gnt_vec = owner_mask & req_vec;
          if ((owner_mask & lock_vec) == 3'b000) begin
            state_d = ARB_IDLE;
          end
        end
      endcase
    end
    rvalid_d = gnt_vec;
  end

  // FSM, owner and response strobe registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ARB_IDLE;
      owner_q  <= ARB_SRC_RF;
      rvalid_q <= 3'b000;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rvalid_q <= rvalid_d;
    end
  end

  // Steer the granted requester onto the RAM port; idle port stays quiet.
  always_comb begin
    ram_req   = |gnt_vec;
    ram_wr_en = '0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (gnt_vec[0]) begin
      ram_wr_en = rf_wr_en;
      ram_addr  = rf_addr;
      ram_wdata = rf_wdata;
    end else if (gnt_vec[1]) begin
      ram_wr_en = ev_wr_en;
      ram_addr  = ev_addr;
      ram_wdata = ev_wdata;
    end else if (gnt_vec[2]) begin
      ram_wr_en = cpu_wr_en;
      ram_addr  = cpu_addr;
      ram_wdata = cpu_wdata;
    end
  end

  assign rf_gnt     = gnt_vec[0];
  assign ev_gnt     = gnt_vec[1];
  assign cpu_gnt    = gnt_vec[2];
  assign rf_rvalid  = rvalid_q[0];
  assign ev_rvalid  = rvalid_q[1];
  assign cpu_rvalid = rvalid_q[2];
  assign rdata      = ram_rdata;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_dcache_dataram_arb.sv
// Bench for dcache_dataram_arb: directed scenarios plus random traffic,
// checked against a transaction-level arbitration/memory model.
module tb_dcache_dataram_arb;

  localparam int NC = 16;
  localparam int AW = 4;
  localparam int DW = 128;
  localparam int AGE_LIMIT = 4;
  localparam int EW = 16 + 3 + DW;
`ifdef DCACHE_ARB_AGING_EN
  localparam bit AGING = 1'b1;
`else
  localparam bit AGING = 1'b0;
`endif

  typedef struct packed {
    logic          gap;
    logic          lock;
    logic [NC-1:0] wr_en;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } op_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0]    req_v = '0, lock_v = '0;
  logic [NC-1:0] wr_en_v [3];
  logic [AW-1:0] addr_v  [3];
  logic [DW-1:0] wdata_v [3];
  logic rf_gnt, ev_gnt, cpu_gnt, rf_rvalid, ev_rvalid, cpu_rvalid;
  logic [DW-1:0] rdata, ram_wdata, ram_rdata;
  logic          ram_req, dbg_state;
  logic [NC-1:0] ram_wr_en;
  logic [AW-1:0] ram_addr;

  dcache_dataram_arb #(.NUM_COL(NC), .COL_WIDTH(8), .ADDR_WIDTH(AW),
                       .DATA_WIDTH(DW), .AGE_LIMIT(AGE_LIMIT)) dut (
    .clk(clk), .rst(rst),
    .rf_req(req_v[0]), .rf_lock(lock_v[0]), .rf_wr_en(wr_en_v[0]),
    .rf_addr(addr_v[0]), .rf_wdata(wdata_v[0]), .rf_gnt(rf_gnt), .rf_rvalid(rf_rvalid),
    .ev_req(req_v[1]), .ev_lock(lock_v[1]), .ev_wr_en(wr_en_v[1]),
    .ev_addr(addr_v[1]), .ev_wdata(wdata_v[1]), .ev_gnt(ev_gnt), .ev_rvalid(ev_rvalid),
    .cpu_req(req_v[2]), .cpu_lock(lock_v[2]), .cpu_wr_en(wr_en_v[2]),
    .cpu_addr(addr_v[2]), .cpu_wdata(wdata_v[2]), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
    .rdata(rdata), .ram_req(ram_req), .ram_wr_en(ram_wr_en), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .dbg_state(dbg_state)
  );

  function automatic logic [DW-1:0] init_line(input int a);
    return {32'(a) * 32'h9E3779B9, ~32'(a), 32'hA5A50000 + 32'(a), 32'(a) << 8};
  endfunction

  function automatic logic [DW-1:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- RAM model (write-first, 1-cycle read) ----------------
  logic [DW-1:0] ram_mem [16];
  logic [DW-1:0] ram_line;
  initial begin
    ram_rdata = '0;
    for (int a = 0; a < 16; a++) ram_mem[a] = init_line(a);
    forever begin
      @(posedge clk);
      if (ram_req) begin
        ram_line = ram_mem[ram_addr];
        for (int b = 0; b < NC; b++)
          if (ram_wr_en[b]) ram_line[b*8 +: 8] = ram_wdata[b*8 +: 8];
        ram_mem[ram_addr] = ram_line;
        ram_rdata <= ram_line;
      end
    end
  end

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  logic [EW-1:0] exp_q[$];
  op_t ops[3][$];
  logic [DW-1:0] ref_mem [16];
  bit   m_locked = 1'b0;
  int   m_owner = 0;
  int   m_age = 0;
  logic [2:0] dut_g;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d: got %h want %h", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_check();
    int win;
    int order[3];
    logic [2:0] exp_g;
    logic [DW-1:0] line;
    win = -1;
    if (!rst) begin
      if (m_locked) begin
        if (req_v[m_owner]) win = m_owner;
      end else begin
        if (AGING && m_age == AGE_LIMIT) order = '{2, 0, 1};
        else order = '{0, 1, 2};
        for (int k = 0; k < 3; k++)
          if (win < 0 && req_v[order[k]]) win = order[k];
      end
    end
    exp_g = (win >= 0) ? 3'(1 << win) : 3'b000;
    dut_g = {cpu_gnt, ev_gnt, rf_gnt};
    check("gnt", DW'(dut_g), DW'(exp_g));
    check("ram_req", DW'(ram_req), DW'(win >= 0));
    if (win < 0) check("ram_wr_en_idle", DW'(ram_wr_en), '0);
    check("state", DW'(dbg_state), DW'(m_locked));
    if (win >= 0) begin
      line = ref_mem[addr_v[win]];
      for (int b = 0; b < NC; b++)
        if (wr_en_v[win][b]) line[b*8 +: 8] = wdata_v[win][b*8 +: 8];
      ref_mem[addr_v[win]] = line;
      exp_q.push_back({16'(cyc), exp_g, line});
    end
    if (rst) begin
      m_locked = 1'b0;
      m_age = 0;
    end else begin
      if (m_locked) begin
        if (!lock_v[m_owner]) m_locked = 1'b0;
      end else if (win >= 0 && lock_v[win]) begin
        m_locked = 1'b1;
        m_owner = win;
      end
      if (win == 2) m_age = 0;
      else if (req_v[2] && m_age < AGE_LIMIT) m_age++;
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [EW-1:0] e;
    logic [2:0] got;
    @(posedge clk);
    forever begin
      @(negedge clk);
      got = {cpu_rvalid, ev_rvalid, rf_rvalid};
      if (exp_q.size() != 0 && exp_q[0][EW-1 -: 16] == 16'(cyc - 1)) begin
        e = exp_q.pop_front();
        check("rvalid", DW'(got), DW'(e[DW+2:DW]));
        check("rdata", rdata, e[DW-1:0]);
      end else begin
        check("rvalid_idle", DW'(got), '0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic op_t mk(input logic gap, input logic lock, input logic [NC-1:0] we,
                             input logic [AW-1:0] a, input logic [DW-1:0] d);
    op_t o;
    o.gap = gap; o.lock = lock; o.wr_en = we; o.addr = a; o.wdata = d;
    return o;
  endfunction

  task automatic drive();
    op_t h;
    for (int s = 0; s < 3; s++) begin
      if (ops[s].size() != 0) begin
        h = ops[s][0];
        req_v[s] = !h.gap; lock_v[s] = h.lock;
        wr_en_v[s] = h.wr_en; addr_v[s] = h.addr; wdata_v[s] = h.wdata;
      end else begin
        req_v[s] = 1'b0; lock_v[s] = 1'b0;
        wr_en_v[s] = NC'($urandom()); addr_v[s] = AW'($urandom()); wdata_v[s] = rnd128();
      end
    end
  endtask

  task automatic cycle();
    drive();
    @(negedge clk);
    model_check();
    @(posedge clk);
    #1;
    cyc++;
    for (int s = 0; s < 3; s++)
      if (ops[s].size() != 0 && (ops[s][0].gap || dut_g[s])) void'(ops[s].pop_front());
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((ops[0].size() + ops[1].size() + ops[2].size()) != 0 && n < 400) begin
      cycle();
      n++;
    end
    check("drain_timeout", DW'(n < 400), DW'(1));
  endtask

  function automatic op_t rnd_op(input logic lock);
    logic [NC-1:0] we;
    case ($urandom_range(0, 3))
      0, 1: we = '0;
      2: we = '1;
      default: we = NC'($urandom());
    endcase
    return mk(1'b0, lock, we, AW'($urandom_range(0, 15)), rnd128());
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    logic [DW-1:0] line_a;
    for (int a = 0; a < 16; a++) ref_mem[a] = init_line(a);
    for (int s = 0; s < 3; s++) begin
      wr_en_v[s] = '0; addr_v[s] = '0; wdata_v[s] = '0;
    end
    repeat (3) cycle();
    rst = 1'b0;
    check("reset_outputs", DW'({rf_gnt, ev_gnt, cpu_gnt, rf_rvalid, ev_rvalid, cpu_rvalid,
                                ram_req, ram_wr_en}), '0);

    // CPU write then read of set 3.
    ops[2].push_back(mk(0, 0, '1, 4'h3, rnd128()));
    ops[2].push_back(mk(0, 0, '0, 4'h3, '0));
    drain();

    // RF full-line write and CPU read of set 7 in the same cycle.
    line_a = rnd128();
    ops[0].push_back(mk(0, 0, 16'hFFFF, 4'h7, line_a));
    ops[2].push_back(mk(0, 0, '0, 4'h7, '0));
    drain();

    // EV locked read/write of set 5; RF shows up while the lock is held.
    ops[1].push_back(mk(0, 1, '0, 4'h5, '0));
    ops[1].push_back(mk(1, 1, '0, 4'h5, '0));
    ops[1].push_back(mk(0, 0, '1, 4'h5, rnd128()));
    cycle();
    ops[0].push_back(mk(0, 0, '0, 4'h5, '0));
    ops[2].push_back(mk(0, 0, '0, 4'h5, '0));
    drain();

    // Reset in the middle of a locked EV sequence.
    ops[1].push_back(mk(0, 1, '0, 4'h9, '0));
    ops[1].push_back(mk(1, 1, '0, 4'h9, '0));
    ops[1].push_back(mk(0, 1, '0, 4'h9, '0));
    ops[1].push_back(mk(0, 0, '1, 4'h9, rnd128()));
    cycle();
    cycle();
    rst = 1'b1;
    cycle();
    #2;
    check("reset_midlock", DW'({rf_gnt, ev_gnt, cpu_gnt, rf_rvalid, ev_rvalid, cpu_rvalid,
                                ram_req, ram_wr_en, dbg_state}), '0);
    for (int s = 0; s < 3; s++) ops[s].delete();
    rst = 1'b0;
    ops[2].push_back(mk(0, 0, '0, 4'h9, '0));
    ops[1].push_back(mk(0, 0, '0, 4'h9, '0));
    ops[0].push_back(mk(0, 0, '0, 4'h9, '0));
    drain();

    // Single-column CPU write, then read back.
    ops[2].push_back(mk(0, 0, 16'h0001, 4'h2, {{15{8'h00}}, 8'hAB}));
    ops[2].push_back(mk(0, 0, '0, 4'h2, '0));
    drain();

    // Continuous RF pressure against CPU (aging cadence when enabled).
    for (int i = 0; i < 12; i++) ops[0].push_back(rnd_op(1'b0));
    for (int i = 0; i < 3; i++) ops[2].push_back(rnd_op(1'b0));
    drain();

    // Random traffic with locked sequences and lock gaps.
    for (int c = 0; c < 2500; c++) begin
      for (int s = 0; s < 3; s++) begin
        if (ops[s].size() == 0 && $urandom_range(0, 99) < 40) begin
          if ($urandom_range(0, 99) < 25) begin
            ops[s].push_back(rnd_op(1'b1));
            if ($urandom_range(0, 1) == 1) ops[s].push_back(mk(1, 1, '0, '0, '0));
            ops[s].push_back(rnd_op(1'b0));
          end else begin
            ops[s].push_back(rnd_op(1'b0));
          end
        end
      end
      cycle();
    end
    drain();
    repeat (4) cycle();
    check("exp_q_empty", DW'(exp_q.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
